afifo_rd_arbiter: RTL and testbench
===================================

AFIFO_RD_ARBITER -- requirements
Module: afifo_rd_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of rdata and out_data.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of read requesters (2..8).
REQ-003 SHALL have parameter MAX_BURST, default 8, largest burst length in beats; BW = clog2(MAX_BURST+1).
REQ-004 SHALL have port rclk  input  1  read-domain clock; all logic on its rising edge.
REQ-005 SHALL have port rrst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rempty  input  1  FIFO read-side empty flag.
REQ-007 SHALL have port rinc  output  1  FIFO read increment; one word popped per cycle high.
REQ-008 SHALL have port rdata  input  DATA_WIDTH  FIFO head word, valid in the same cycle as rinc.
REQ-009 SHALL have port req  input  NUM_REQ  per-requester read request, level.
REQ-010 SHALL have port rdy  input  NUM_REQ  per-requester able to accept a word this cycle.
REQ-011 SHALL have port cfg_burst  input  BW  beats per grant; 0 means 1, values above MAX_BURST clamp to MAX_BURST.
REQ-012 SHALL have port gnt  output  NUM_REQ  one-hot current grant, all-zero when idle.
REQ-013 SHALL have port out_data  output  DATA_WIDTH  registered popped word.
REQ-014 SHALL have port out_valid  output  NUM_REQ  one-hot; bit i high for one cycle when out_data belongs to requester i.
REQ-015 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-016 SHALL implement an FSM with states IDLE and BURST.
REQ-017 In IDLE, with any req bit high, SHALL pick the first requesting index at or after rr_ptr (wrapping modulo NUM_REQ), load gnt, latch the effective cfg_burst into beat_target, clear beat_cnt, and enter BURST next cycle; rinc SHALL be low in IDLE.
REQ-018 In BURST, rinc SHALL equal !rempty && req[g] && rdy[g], where g is the granted index; rinc combinational from these inputs and registered state.
REQ-019 Each cycle rinc is high SHALL register rdata into out_data and set out_valid[g] in the next cycle (latency 1); otherwise out_valid SHALL be all-zero and out_data SHALL hold.
REQ-020 beat_cnt SHALL increment on each rinc; the grant SHALL end in the cycle beat_cnt+1 equals beat_target with rinc high.
REQ-021 The grant SHALL also end in any BURST cycle where req[g] is low (requester abandons); no pop occurs that cycle.
REQ-022 On grant end the FSM SHALL return to IDLE, clear gnt, and set rr_ptr to (g+1) mod NUM_REQ; a new grant needs at least one IDLE cycle.
REQ-023 rempty high or rdy[g] low in BURST SHALL stall (hold state, beat_cnt, gnt) with no timeout.
REQ-024 Changes on cfg_burst during BURST SHALL NOT affect the current grant.
REQ-025 gnt SHALL never have more than one bit set; out_valid SHALL never have more than one bit set.
REQ-026 rinc SHALL never be high while rempty is high.

Reset
REQ-027 On rrst_n low, asynchronously: state=IDLE, gnt=0, rr_ptr=0, beat_cnt=0, beat_target=0, out_data=0, out_valid=0, busy=0; rinc SHALL be 0 throughout reset.
REQ-028 Reset asserted mid-burst SHALL abandon the burst; no out_valid for the in-flight word after reset release.
REQ-029 After rrst_n deasserts, the first grant SHALL occur no earlier than the first rising edge with rrst_n high.

Structure
REQ-030 The FSM state enum and the burst-length clamp function SHALL live in afifo_txn_pkg for reuse by the read agent and scoreboard.
REQ-031 The round-robin pick SHALL be a sub-module afifo_rr_picker (inputs req, rr_ptr; output one-hot pick), combinational, parameterised by NUM_REQ.
REQ-032 Top level SHALL contain the FSM, counters and output registers only.

Verification
REQ-033 Single requester: req=4'b0001, rdy=all 1, cfg_burst=3, FIFO holds 5 words -> exactly 3 rinc pulses, out_valid[0] 3 cycles each one cycle after its rinc, IDLE, then second grant pops 2, stalls on empty.
REQ-034 Round-robin: req=4'b1111, cfg_burst=2, FIFO never empty -> grants in order 0,1,2,3,0, each 2 beats, one IDLE cycle between.
REQ-035 Backpressure/empty: during grant to 2, rdy[2] low 3 cycles then rempty high 2 cycles -> rinc low those 5 cycles, beat_cnt unchanged, grant held.
REQ-036 Abandon: req[1] drops after 1 of 4 beats -> IDLE next cycle, rr_ptr=2, no further pop for 1.
REQ-037 Reset mid-burst: rrst_n low during beat 2 of 4 -> all outputs 0 immediately, rinc 0, after release grant restarts from requester 0.
REQ-038 Clamp: cfg_burst=0 -> 1 beat per grant; cfg_burst=15 with MAX_BURST=8 -> 8 beats.

Source files
------------

// File: rtl/afifo_txn_pkg.sv
// Shared types and helpers for the async-FIFO read side: arbiter FSM states
// and the burst-length clamp used by the arbiter, read agent and scoreboard.
package afifo_txn_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // A zero burst still moves one word; oversize requests saturate at the maximum.
    function automatic int unsigned clamp_burst(input int unsigned cfg,
                                                input int unsigned max_burst);
        int unsigned eff;
        if (cfg == 32'd0) begin
            eff = 32'd1;
        end else if (cfg > max_burst) begin
            eff = max_burst;
        end else begin
            eff = cfg;
        end
        return eff;
    endfunction

endpackage

// File: rtl/afifo_rr_picker.sv
// Round-robin picker: one-hot select of the first requester at or after
// rr_ptr, wrapping modulo NUM_REQ. Purely combinational.
module afifo_rr_picker #(
    parameter int NUM_REQ = 4,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] pick
);

    // Scan from rr_ptr upward and keep only the first hit.
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = PW'((int'(rr_ptr) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/afifo_rd_arbiter.sv
// Read-side arbiter for an async FIFO: grants bursts of pops to NUM_REQ
// requesters in round-robin order and forwards each popped word one cycle later.
module afifo_rd_arbiter
    import afifo_txn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 8,
    localparam int BW = $clog2(MAX_BURST + 1),
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    output logic                  rinc,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    rdy,
    input  logic [BW-1:0]         cfg_burst,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_REQ-1:0]    out_valid,
    output logic                  busy
);

    arb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [PW-1:0]         gidx_q, gidx_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [BW-1:0]         beat_target_q, beat_target_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [NUM_REQ-1:0]    out_valid_q;

    logic [NUM_REQ-1:0]    pick_s;
    logic [PW-1:0]         pick_idx_s;
    logic                  req_g_s;
    logic                  rdy_g_s;
    logic                  rinc_s;
    logic [PW-1:0]         rr_next_s;

    afifo_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .pick   (pick_s)
    );

    // Encode the picker's one-hot result into the index kept for the grant.
    always_comb begin
        pick_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_s[i]) begin
                pick_idx_s = PW'(i);
            end else begin
                pick_idx_s = pick_idx_s;
            end
        end
    end

    assign req_g_s   = req[gidx_q];
    assign rdy_g_s   = rdy[gidx_q];
    assign rinc_s    = (state_q == ST_BURST) && !rempty && req_g_s && rdy_g_s;
    assign rr_next_s = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + PW'(1);

    // Next-state logic: grant in IDLE, count beats in BURST, end on last beat or abandon.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        gidx_d        = gidx_q;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        beat_target_d = beat_target_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d       = ST_BURST;
                    gnt_d         = pick_s;
                    gidx_d        = pick_idx_s;
                    beat_cnt_d    = '0;
                    beat_target_d = BW'(clamp_burst(32'(cfg_burst), MAX_BURST));
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                // Abandon has priority; a stalled cycle simply holds everything.
                if (!req_g_s || (rinc_s && (beat_cnt_q + BW'(1) == beat_target_q))) begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = rr_next_s;
                end else if (rinc_s) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // FSM, grant and beat counter registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '0;
            gidx_q        <= '0;
            rr_ptr_q      <= '0;
            beat_cnt_q    <= '0;
            beat_target_q <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gidx_q        <= gidx_d;
            rr_ptr_q      <= rr_ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            beat_target_q <= beat_target_d;
        end
    end

    // Output stage: capture the popped word and tag it with the owning requester.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            out_data_q  <= '0;
            out_valid_q <= '0;
        end else if (rinc_s) begin
            out_data_q  <= rdata;
            out_valid_q <= gnt_q;
        end else begin
            out_valid_q <= '0;
        end
    end

    assign rinc      = rinc_s;
    assign gnt       = gnt_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_BURST);

endmodule

// File: tb/tb_afifo_rd_arbiter.sv
// Directed, table-driven bench for afifo_rd_arbiter with a small FIFO-level model.
module tb_afifo_rd_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int MB = 8;
    localparam int BW = 4;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          rempty;
    logic          rinc;
    logic [DW-1:0] rdata;
    logic [NR-1:0] req;
    logic [NR-1:0] rdy;
    logic [BW-1:0] cfg_burst;
    logic [NR-1:0] gnt;
    logic [DW-1:0] out_data;
    logic [NR-1:0] out_valid;
    logic          busy;

    afifo_rd_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .rinc      (rinc),
        .rdata     (rdata),
        .req       (req),
        .rdy       (rdy),
        .cfg_burst (cfg_burst),
        .gnt       (gnt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic [3:0] rq;
        logic [3:0] rd;
        logic [3:0] cf;
        logic       em;
        logic [3:0] g;
        logic       ri;
        logic [3:0] ov;
        logic       bz;
    } vec_t;

    vec_t    vecs[$];
    int      total = 0;
    int      bad = 0;
    int      lvl = 0;
    logic    force_emp = 1'b0;
    logic [DW-1:0] head = 32'hC0DE_0000;
    logic [DW-1:0] last_pop = 32'h0;
    logic    pend_pop = 1'b0;
    logic [DW-1:0] pend_data = 32'h0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic upd();
        rempty = force_emp || (lvl == 0);
        rdata  = head;
    endtask

    task automatic half_a();
        @(negedge rclk);
        pend_pop  = rinc;
        pend_data = rdata;
        chk("rinc_while_empty", 32'(rinc & rempty), 32'd0);
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        chk("ov_onehot", 32'($countones(out_valid) <= 1), 32'd1);
    endtask

    task automatic half_b();
        @(posedge rclk);
        #1;
        if (pend_pop) begin
            last_pop = pend_data;
            head     = head + 32'd1;
            if (lvl > 0) lvl = lvl - 1;
        end
        pend_pop = 1'b0;
        upd();
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        req = 4'b0000; rdy = 4'b1111; cfg_burst = 4'd0; force_emp = 1'b0;
        upd();
        repeat (2) @(posedge rclk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rinc", 32'(rinc), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        @(negedge rclk);
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;
    endtask

    task automatic add(input logic [3:0] rq, input logic [3:0] rd, input logic [3:0] cf,
                       input logic em, input logic [3:0] g, input logic ri,
                       input logic [3:0] ov, input logic bz);
        vec_t v;
        v.rq = rq; v.rd = rd; v.cf = cf; v.em = em;
        v.g = g; v.ri = ri; v.ov = ov; v.bz = bz;
        vecs.push_back(v);
    endtask

    initial begin
        logic [9:0] e_rinc;
        logic [9:0] e_gnt;
        logic [9:0] e_ov;

        // Round robin, cfg_burst=2: grants 0,1,2,3,0 with one IDLE cycle between.
        add(4'hF,4'hF,4'd2,1'b0, 4'h0,1'b0,4'h0,1'b0);
        add(4'hF,4'hF,4'd2,1'b0, 4'h1,1'b1,4'h0,1'b1);
        add(4'hF,4'hF,4'd2,1'b0, 4'h1,1'b1,4'h1,1'b1);
        add(4'hF,4'hF,4'd2,1'b0, 4'h0,1'b0,4'h1,1'b0);
        add(4'hF,4'hF,4'd2,1'b0, 4'h2,1'b1,4'h0,1'b1);
        add(4'hF,4'hF,4'd2,1'b0, 4'h2,1'b1,4'h2,1'b1);
        add(4'hF,4'hF,4'd2,1'b0, 4'h0,1'b0,4'h2,1'b0);
        add(4'hF,4'hF,4'd2,1'b0, 4'h4,1'b1,4'h0,1'b1);
        add(4'hF,4'hF,4'd2,1'b0, 4'h4,1'b1,4'h4,1'b1);
        add(4'hF,4'hF,4'd2,1'b0, 4'h0,1'b0,4'h4,1'b0);
        add(4'hF,4'hF,4'd2,1'b0, 4'h8,1'b1,4'h0,1'b1);
        add(4'hF,4'hF,4'd2,1'b0, 4'h8,1'b1,4'h8,1'b1);
        add(4'hF,4'hF,4'd2,1'b0, 4'h0,1'b0,4'h8,1'b0);
        add(4'hF,4'hF,4'd2,1'b0, 4'h1,1'b1,4'h0,1'b1);
        add(4'hF,4'hF,4'd2,1'b0, 4'h1,1'b1,4'h1,1'b1);
        add(4'h0,4'hF,4'd2,1'b0, 4'h0,1'b0,4'h1,1'b0);
        // Clamp: cfg 0 -> 1 beat, cfg 15 -> 8 beats; cfg changes mid-burst are ignored.
        add(4'h1,4'hF,4'd0,1'b0, 4'h0,1'b0,4'h0,1'b0);
        add(4'h1,4'hF,4'd0,1'b0, 4'h1,1'b1,4'h0,1'b1);
        add(4'h1,4'hF,4'd15,1'b0, 4'h0,1'b0,4'h1,1'b0);
        add(4'h1,4'hF,4'd15,1'b0, 4'h1,1'b1,4'h0,1'b1);
        for (int k = 0; k < 7; k++) add(4'h1,4'hF,4'd1,1'b0, 4'h1,1'b1,4'h1,1'b1);
        add(4'h0,4'hF,4'd1,1'b0, 4'h0,1'b0,4'h1,1'b0);
        add(4'h0,4'hF,4'd1,1'b0, 4'h0,1'b0,4'h0,1'b0);
        // Backpressure then empty during a 4-beat grant to requester 2.
        add(4'h4,4'hF,4'd4,1'b0, 4'h0,1'b0,4'h0,1'b0);
        add(4'h4,4'hF,4'd4,1'b0, 4'h4,1'b1,4'h0,1'b1);
        add(4'h4,4'hB,4'd4,1'b0, 4'h4,1'b0,4'h4,1'b1);
        add(4'h4,4'hB,4'd4,1'b0, 4'h4,1'b0,4'h0,1'b1);
        add(4'h4,4'hB,4'd4,1'b0, 4'h4,1'b0,4'h0,1'b1);
        add(4'h4,4'hF,4'd4,1'b1, 4'h4,1'b0,4'h0,1'b1);
        add(4'h4,4'hF,4'd4,1'b1, 4'h4,1'b0,4'h0,1'b1);
        add(4'h4,4'hF,4'd4,1'b0, 4'h4,1'b1,4'h0,1'b1);
        add(4'h4,4'hF,4'd4,1'b0, 4'h4,1'b1,4'h4,1'b1);
        add(4'h4,4'hF,4'd4,1'b0, 4'h4,1'b1,4'h4,1'b1);
        add(4'h0,4'hF,4'd4,1'b0, 4'h0,1'b0,4'h4,1'b0);
        // Abandon by requester 1 after one beat; next pick starts at 2.
        add(4'h2,4'hF,4'd4,1'b0, 4'h0,1'b0,4'h0,1'b0);
        add(4'h2,4'hF,4'd4,1'b0, 4'h2,1'b1,4'h0,1'b1);
        add(4'h0,4'hF,4'd4,1'b0, 4'h2,1'b0,4'h2,1'b1);
        add(4'h6,4'hF,4'd4,1'b0, 4'h0,1'b0,4'h0,1'b0);
        add(4'h6,4'hF,4'd4,1'b0, 4'h4,1'b1,4'h0,1'b1);
        add(4'h0,4'hF,4'd4,1'b0, 4'h4,1'b0,4'h4,1'b1);
        add(4'h0,4'hF,4'd4,1'b0, 4'h0,1'b0,4'h0,1'b0);

        rempty = 1'b1; rdata = '0; req = '0; rdy = '0; cfg_burst = '0;
        #1;
        chk("rst_rinc_early", 32'(rinc), 32'd0);
        do_reset();

        // Single requester, five words, burst of 3, then second grant stalls on empty.
        lvl = 5; req = 4'b0001; rdy = 4'b1111; cfg_burst = 4'd3;
        upd();
        e_rinc = 10'b0001101110;
        e_gnt  = 10'b1111101110;
        e_ov   = 10'b0011011100;
        for (int c = 0; c < 10; c++) begin
            half_a();
            chk($sformatf("single_rinc[%0d]", c), 32'(rinc), 32'(e_rinc[c]));
            chk($sformatf("single_gnt[%0d]", c), 32'(gnt), 32'(e_gnt[c]));
            chk($sformatf("single_ov[%0d]", c), 32'(out_valid), 32'(e_ov[c]));
            if (e_ov[c]) chk($sformatf("single_data[%0d]", c), out_data, last_pop);
            half_b();
        end
        chk("single_busy_stall", 32'(busy), 32'd1);
        chk("single_words_left", 32'(lvl), 32'd0);

        do_reset();
        lvl = 1000;
        upd();
        foreach (vecs[i]) begin
            req = vecs[i].rq; rdy = vecs[i].rd; cfg_burst = vecs[i].cf; force_emp = vecs[i].em;
            upd();
            half_a();
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].g));
            chk($sformatf("v%0d_rinc", i), 32'(rinc), 32'(vecs[i].ri));
            chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bz));
            if (vecs[i].ov != 4'h0) chk($sformatf("v%0d_data", i), out_data, last_pop);
            half_b();
        end

        // Reset during beat 2 of a 4-beat grant to requester 3.
        req = 4'b1111; rdy = 4'b1111; cfg_burst = 4'd4; force_emp = 1'b0;
        upd();
        half_a();
        chk("mid_idle_gnt", 32'(gnt), 32'd0);
        half_b();
        half_a();
        chk("mid_gnt3", 32'(gnt), 32'h8);
        chk("mid_beat1", 32'(rinc), 32'd1);
        half_b();
        #2;
        rrst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_rinc", 32'(rinc), 32'd0);
        chk("mid_rst_ov", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        @(posedge rclk);
        #1;
        chk("mid_held_rinc", 32'(rinc), 32'd0);
        chk("mid_held_gnt", 32'(gnt), 32'd0);
        @(negedge rclk);
        rrst_n = 1'b1;
        #1;
        chk("mid_rel_ov", 32'(out_valid), 32'd0);
        chk("mid_rel_gnt", 32'(gnt), 32'd0);
        @(posedge rclk);
        #1;
        half_a();
        chk("mid_restart_gnt", 32'(gnt), 32'h1);
        chk("mid_restart_ov", 32'(out_valid), 32'd0);
        chk("mid_restart_rinc", 32'(rinc), 32'd1);
        half_b();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
